// File: rtl/pipeline_hazard_controller.sv
// ============================================================================
//  Module      : pipeline_hazard_controller
//  Description : Stall/flush sequencer for the five-stage pipeline. Resolves
//                load-use hazards, memory-stage redirects and multi-cycle
//                data-memory accesses (with a timeout watchdog), and keeps
//                saturating stall/flush performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int WAIT_W      = $clog2(MEM_TIMEOUT + 2)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  decodeRs1,
  input  logic [4:0]  decodeRs2,
  input  logic        decodeUsesRs1,
  input  logic        decodeUsesRs2,
  input  logic [4:0]  executeRd,
  input  logic        executeMemoryReadEnable,
  input  logic        redirectTaken,
  input  logic        memRequest,
  input  logic        memReady,
  output logic        stallFetch,
  output logic        stallDecode,
  output logic        stallExecute,
  output logic        stallMemory,
  output logic        flushDecode,
  output logic        flushExecute,
  output logic        flushMemory,
  output logic        flushWriteback,
  output logic        pcRedirect,
  output logic        memTimeoutError,
  output logic [31:0] stallCycleCount,
  output logic [15:0] flushCount
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;
  localparam bit                WATCHDOG_EN = (MEM_TIMEOUT != 0);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_count_q, wait_count_d;
  logic              mem_timeout_error_q, mem_timeout_error_d;
  logic [31:0]       stall_cycle_count_q, stall_cycle_count_d;
  logic [15:0]       flush_count_q, flush_count_d;

  logic load_use;
  logic mem_wait;
  logic any_stall;

  // Hazard detection: load in execute feeding decode, and pending memory access
  always_comb begin
    load_use = executeMemoryReadEnable && (executeRd != 5'd0) &&
               ((decodeUsesRs1 && (decodeRs1 == executeRd)) ||
                (decodeUsesRs2 && (decodeRs2 == executeRd)));
    mem_wait = ((state_q == ST_RUN) && memRequest && !memReady) ||
               ((state_q == ST_MEM_WAIT) && !memReady);
  end

  // Prioritised stall/flush outputs: error > memory wait > redirect > load-use
  always_comb begin
    stallFetch     = 1'b0;
    stallDecode    = 1'b0;
    stallExecute   = 1'b0;
    stallMemory    = 1'b0;
    flushDecode    = 1'b0;
    flushExecute   = 1'b0;
    flushMemory    = 1'b0;
    flushWriteback = 1'b0;
    pcRedirect     = 1'b0;
    if (state_q == ST_ERROR) begin
      stallFetch   = 1'b1;
      stallDecode  = 1'b1;
      stallExecute = 1'b1;
      stallMemory  = 1'b1;
    end else if (mem_wait) begin
      // Execute-to-memory is held, so any redirect comes back after the wait
      stallFetch     = 1'b1;
      stallDecode    = 1'b1;
      stallExecute   = 1'b1;
      stallMemory    = 1'b1;
      flushWriteback = 1'b1;
    end else if (redirectTaken) begin
      // Younger instructions are squashed, which also covers any load-use
      flushDecode  = 1'b1;
      flushExecute = 1'b1;
      flushMemory  = 1'b1;
      pcRedirect   = 1'b1;
    end else if (load_use) begin
      stallFetch   = 1'b1;
      stallDecode  = 1'b1;
      flushExecute = 1'b1;
    end
    any_stall = stallFetch | stallDecode | stallExecute | stallMemory;
  end

  // Memory wait-state machine with watchdog
  always_comb begin
    state_d      = state_q;
    wait_count_d = wait_count_q;
    case (state_q)
      ST_RUN: begin
        if (memRequest && !memReady) begin
          state_d      = ST_MEM_WAIT;
          wait_count_d = {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_MEM_WAIT: begin
        if (memReady) begin
          state_d      = ST_RUN;
          wait_count_d = '0;
        end else if (WATCHDOG_EN && (wait_count_q == TIMEOUT_CNT)) begin
          state_d = ST_ERROR;
        end else if (wait_count_q != WAIT_MAX) begin
          // Saturate so a disabled watchdog never wraps the counter
          wait_count_d = wait_count_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d      = ST_RUN;
        wait_count_d = '0;
      end
    endcase
    mem_timeout_error_d = mem_timeout_error_q | (state_d == ST_ERROR);
  end

  // Saturating performance counters
  always_comb begin
    stall_cycle_count_d = stall_cycle_count_q;
    flush_count_d       = flush_count_q;
    if (any_stall && (stall_cycle_count_q != 32'hFFFF_FFFF)) begin
      stall_cycle_count_d = stall_cycle_count_q + 32'd1;
    end
    if (pcRedirect && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  // State, watchdog and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q             <= ST_RUN;
      wait_count_q        <= '0;
      mem_timeout_error_q <= 1'b0;
      stall_cycle_count_q <= 32'd0;
      flush_count_q       <= 16'd0;
    end else begin
      state_q             <= state_d;
      wait_count_q        <= wait_count_d;
      mem_timeout_error_q <= mem_timeout_error_d;
      stall_cycle_count_q <= stall_cycle_count_d;
      flush_count_q       <= flush_count_d;
    end
  end

  assign memTimeoutError = mem_timeout_error_q;
  assign stallCycleCount = stall_cycle_count_q;
  assign flushCount      = flush_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
// ============================================================================
//  Module      : tb_pipeline_hazard_controller
//  Description : Directed self-checking bench for pipeline_hazard_controller
//                (instantiated with a short watchdog timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_controller;

  logic        clock;
  logic        reset;
  logic [4:0]  decodeRs1, decodeRs2, executeRd;
  logic        decodeUsesRs1, decodeUsesRs2;
  logic        executeMemoryReadEnable, redirectTaken, memRequest, memReady;
  logic        stallFetch, stallDecode, stallExecute, stallMemory;
  logic        flushDecode, flushExecute, flushMemory, flushWriteback;
  logic        pcRedirect, memTimeoutError;
  logic [31:0] stallCycleCount;
  logic [15:0] flushCount;

  int checks = 0;
  int errors = 0;

  // Output vector order: sF sD sE sM fD fE fM fW pc
  localparam logic [8:0] O_NONE = 9'b0000_0000_0;
  localparam logic [8:0] O_LU   = 9'b1100_0100_0;
  localparam logic [8:0] O_RED  = 9'b0000_1110_1;
  localparam logic [8:0] O_MW   = 9'b1111_0001_0;
  localparam logic [8:0] O_ERR  = 9'b1111_0000_0;

  logic [8:0] outs;
  assign outs = {stallFetch, stallDecode, stallExecute, stallMemory,
                 flushDecode, flushExecute, flushMemory, flushWriteback, pcRedirect};

  pipeline_hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .decodeRs1               (decodeRs1),
    .decodeRs2               (decodeRs2),
    .decodeUsesRs1           (decodeUsesRs1),
    .decodeUsesRs2           (decodeUsesRs2),
    .executeRd               (executeRd),
    .executeMemoryReadEnable (executeMemoryReadEnable),
    .redirectTaken           (redirectTaken),
    .memRequest              (memRequest),
    .memReady                (memReady),
    .stallFetch              (stallFetch),
    .stallDecode             (stallDecode),
    .stallExecute            (stallExecute),
    .stallMemory             (stallMemory),
    .flushDecode             (flushDecode),
    .flushExecute            (flushExecute),
    .flushMemory             (flushMemory),
    .flushWriteback          (flushWriteback),
    .pcRedirect              (pcRedirect),
    .memTimeoutError         (memTimeoutError),
    .stallCycleCount         (stallCycleCount),
    .flushCount              (flushCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; return 1 time unit after it
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    decodeRs1 = 5'd0; decodeRs2 = 5'd0; executeRd = 5'd0;
    decodeUsesRs1 = 1'b0; decodeUsesRs2 = 1'b0;
    executeMemoryReadEnable = 1'b0; redirectTaken = 1'b0;
    memRequest = 1'b0; memReady = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("reset_outs", 32'(outs), 32'(O_NONE));
    check("reset_stallcnt", stallCycleCount, 32'd0);
    check("reset_flushcnt", 32'(flushCount), 32'd0);
    check("reset_err", 32'(memTimeoutError), 32'd0);

    // Load-use on rs1
    executeMemoryReadEnable = 1'b1; executeRd = 5'd5; decodeRs1 = 5'd5; decodeUsesRs1 = 1'b1;
    #1 check("lu_rs1", 32'(outs), 32'(O_LU));
    tick();
    executeMemoryReadEnable = 1'b0; executeRd = 5'd0;   // bubble now in execute
    #1 check("lu_after", 32'(outs), 32'(O_NONE));
    check("lu_stallcnt", stallCycleCount, 32'd1);

    // Load to x0 never stalls
    executeMemoryReadEnable = 1'b1; executeRd = 5'd0; decodeRs1 = 5'd0;
    #1 check("lu_x0", 32'(outs), 32'(O_NONE));
    tick();
    check("lu_x0_cnt", stallCycleCount, 32'd1);

    // Load-use on rs2; matching rs1 without use does not count
    executeRd = 5'd7; decodeRs2 = 5'd7; decodeUsesRs2 = 1'b1;
    decodeRs1 = 5'd9; decodeUsesRs1 = 1'b1;
    #1 check("lu_rs2", 32'(outs), 32'(O_LU));
    tick();
    decodeUsesRs2 = 1'b0; decodeRs1 = 5'd7; decodeUsesRs1 = 1'b0;
    #1 check("lu_nouse", 32'(outs), 32'(O_NONE));
    check("lu_rs2_cnt", stallCycleCount, 32'd2);

    // Redirect overrides load-use
    decodeRs1 = 5'd5; decodeUsesRs1 = 1'b1; executeRd = 5'd5; redirectTaken = 1'b1;
    #1 check("redirect", 32'(outs), 32'(O_RED));
    tick();
    idle_inputs();
    #1 check("redirect_flushcnt", 32'(flushCount), 32'd1);
    check("redirect_stallcnt", stallCycleCount, 32'd2);

    // Memory access with 4-cycle latency: 3 stall cycles
    memRequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("memwait", 32'(outs), 32'(O_MW));
      tick();
    end
    memReady = 1'b1;
    #1 check("mem_done", 32'(outs), 32'(O_NONE));
    tick();
    check("mem_stallcnt", stallCycleCount, 32'd5);
    // Same-cycle completion back in RUN
    #1 check("mem_same_cycle", 32'(outs), 32'(O_NONE));
    tick();
    check("mem_same_cnt", stallCycleCount, 32'd5);

    // Memory wait beats redirect; redirect honoured once the access completes
    memReady = 1'b0; redirectTaken = 1'b1;
    #1 check("prio_mw_red", 32'(outs), 32'(O_MW));
    tick();
    check("prio_flushcnt", 32'(flushCount), 32'd1);
    memReady = 1'b1;
    #1 check("prio_red_after", 32'(outs), 32'(O_RED));
    tick();
    idle_inputs();
    #1 check("prio_flushcnt2", 32'(flushCount), 32'd2);
    check("prio_stallcnt", stallCycleCount, 32'd6);

    // Watchdog: 5 stall cycles in RUN/MEM_WAIT then ERROR
    memRequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check("wd_wait", 32'(outs), 32'(O_MW));
      check("wd_err_low", 32'(memTimeoutError), 32'd0);
      tick();
    end
    check("wd_err_set", 32'(memTimeoutError), 32'd1);
    check("wd_stallcnt", stallCycleCount, 32'd11);
    redirectTaken = 1'b1; memReady = 1'b1;
    #1 check("wd_error_outs", 32'(outs), 32'(O_ERR));
    tick();
    check("wd_err_sticky", 32'(memTimeoutError), 32'd1);
    check("wd_stallcnt2", stallCycleCount, 32'd12);
    check("wd_flushcnt", 32'(flushCount), 32'd2);

    // Reset out of ERROR
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 check("rst2_outs", 32'(outs), 32'(O_NONE));
    check("rst2_err", 32'(memTimeoutError), 32'd0);
    check("rst2_stallcnt", stallCycleCount, 32'd0);
    check("rst2_flushcnt", 32'(flushCount), 32'd0);

    // Flush counter saturation
    redirectTaken = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clock);
    end
    #1 check("sat_flushcnt", 32'(flushCount), 32'h0000_FFFF);
    tick();
    check("sat_hold", 32'(flushCount), 32'h0000_FFFF);
    check("sat_stallcnt", stallCycleCount, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
